// File: rtl/cpu_pkg.sv
// Shared CP0 definitions: register addresses ({rd,sel}), ExcCode values and
// Status/Cause bit positions.
package cpu_pkg;

  localparam logic [7:0] CP0_BADVADDR = 8'h40;  // rd 8,  sel 0
  localparam logic [7:0] CP0_COUNT    = 8'h48;  // rd 9,  sel 0
  localparam logic [7:0] CP0_COMPARE  = 8'h58;  // rd 11, sel 0
  localparam logic [7:0] CP0_STATUS   = 8'h60;  // rd 12, sel 0
  localparam logic [7:0] CP0_CAUSE    = 8'h68;  // rd 13, sel 0
  localparam logic [7:0] CP0_EPC      = 8'h70;  // rd 14, sel 0

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on a
// Count==Compare match and is cleared only by a write to Compare.
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tog;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '0;
      tog     <= 1'b0;
      ti      <= 1'b0;
    end else begin
      tog   <= ~tog;
      count <= count_we ? wdata : count + {31'b0, tog};
      if (compare_we) compare <= wdata;
      // a Compare write beats a match seen in the same cycle
      if (compare_we)            ti <= 1'b0;
      else if (count == compare) ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: WB-stage event prioritisation, redirect/flush, and the
// Status/Cause/EPC/BadVAddr register file with a Count/Compare timer.
module cp0_exc_unit
  import cpu_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_BASE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_valid,
  input  logic                  syscall,
  input  logic                  brk,
  input  logic                  ov,
  input  logic                  adel,
  input  logic                  ades,
  input  logic                  ri,
  input  logic                  eret,
  input  logic                  mtc0,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           bad_addr,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           cp0_rdata,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic                  cancel
);

  logic [7:0]            im;
  logic                  exl, ie;
  logic [1:0]            sw_ip;
  logic [NUM_HW_INT-1:0] hw_q;
  exc_code_t             exc_code;
  logic [31:0]           epc, badvaddr, count, compare;
  logic                  ti;
  logic [7:0]            ip;
  logic                  int_pend, take_exc, take_eret, wr;
  exc_code_t             code;

  // With six lines, hw_int[5] shares IP[7] with the timer interrupt
  assign ip       = (8'(hw_q) << 2) | {ti, 5'b0, sw_ip};
  assign int_pend = ie & ~exl & |(ip & im);

  always_comb begin
    take_exc = 1'b0;
    code     = EXC_INT;
    if (wb_valid) begin
      take_exc = 1'b1;
      if      (int_pend) code = EXC_INT;
      else if (adel)     code = EXC_ADEL;
      else if (ri)       code = EXC_RI;
      else if (ov)       code = EXC_OV;
      else if (syscall)  code = EXC_SYS;
      else if (brk)      code = EXC_BP;
      else if (ades)     code = EXC_ADES;
      else               take_exc = 1'b0;
    end
  end

  assign take_eret = wb_valid & eret & ~take_exc;
  assign exc_valid = take_exc | take_eret;
  assign cancel    = exc_valid;
  assign exc_pc    = take_eret ? epc : EXC_BASE;
  assign wr        = wb_valid & mtc0 & ~exc_valid;

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr && cp0_addr == CP0_COUNT),
    .compare_we (wr && cp0_addr == CP0_COMPARE),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      sw_ip    <= '0;
      hw_q     <= '0;
      exc_code <= EXC_INT;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      hw_q <= hw_int;
      if (take_exc) begin
        exc_code <= code;
        exl      <= 1'b1;
        if (!exl) epc <= wb_pc;
        if (code == EXC_ADEL || code == EXC_ADES) badvaddr <= bad_addr;
      end else if (take_eret) begin
        exl <= 1'b0;
      end else if (wr) begin
        case (cp0_addr)
          CP0_STATUS: begin
            im  <= cp0_wdata[SR_IM_LO +: 8];
            exl <= cp0_wdata[SR_EXL];
            ie  <= cp0_wdata[SR_IE];
          end
          CP0_CAUSE: sw_ip <= cp0_wdata[CAUSE_IP_LO +: 2];
          CP0_EPC:   epc   <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS: begin
        cp0_rdata[SR_IM_LO +: 8] = im;
        cp0_rdata[SR_EXL]        = exl;
        cp0_rdata[SR_IE]         = ie;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_TI]          = ti;
        cp0_rdata[CAUSE_IP_LO +: 8]  = ip;
        cp0_rdata[CAUSE_EXC_LO +: 5] = exc_code;
      end
      CP0_EPC: cp0_rdata = epc;
      default: cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural CP0 model.
module tb_cp0_exc_unit;

  localparam int NHW = 2;
  localparam int EV_NONE = -1;
  localparam int EV_ERET = 99;
  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_COMPARE = 8'h58,
                         A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic clk = 1'b0, resetn = 1'b0;
  logic wb_valid = 0, syscall = 0, brk = 0, ov = 0, adel = 0, ades = 0, ri = 0, eret = 0, mtc0 = 0;
  logic [7:0]     cp0_addr = '0;
  logic [31:0]    cp0_wdata = '0, wb_pc = '0, bad_addr = '0;
  logic [NHW-1:0] hw_int = '0;
  logic [31:0]    cp0_rdata, exc_pc;
  logic           exc_valid, cancel;

  cp0_exc_unit #(.NUM_HW_INT(NHW), .EXC_BASE(32'h0000_0000)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .syscall(syscall), .brk(brk),
    .ov(ov), .adel(adel), .ades(ades), .ri(ri), .eret(eret), .mtc0(mtc0),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .wb_pc(wb_pc), .bad_addr(bad_addr),
    .hw_int(hw_int), .cp0_rdata(cp0_rdata), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .cancel(cancel)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // behavioural model state
  bit             m_live = 0;
  logic [31:0]    m_count, m_compare, m_epc, m_badv;
  logic           m_tog, m_ti, m_exl, m_ie;
  logic [7:0]     m_im;
  logic [1:0]     m_sw;
  logic [NHW-1:0] m_hwq;
  logic [4:0]     m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_ip();
    return (8'(m_hwq) << 2) | {m_ti, 7'b0} | {6'b0, m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      A_BADV:    return m_badv;
      A_COUNT:   return m_count;
      A_COMPARE: return m_compare;
      A_STATUS:  return {16'b0, m_im, 6'b0, m_exl, m_ie};
      A_CAUSE:   return {1'b0, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
      A_EPC:     return m_epc;
      default:   return 32'h0;
    endcase
  endfunction

  // Events in priority order with their ExcCode
  function automatic int m_event();
    bit f[7];
    int codes[7] = '{0, 4, 10, 12, 8, 9, 5};
    if (!wb_valid) return EV_NONE;
    f = '{(m_ie && !m_exl && (|(m_ip() & m_im))), adel, ri, ov, syscall, brk, ades};
    for (int i = 0; i < 7; i++) if (f[i]) return codes[i];
    return eret ? EV_ERET : EV_NONE;
  endfunction

  task automatic sample();
    int ev;
    @(negedge clk);
    if (m_live) begin
      ev = m_event();
      chk("exc_valid", exc_valid, ev != EV_NONE);
      chk("cancel", cancel, ev != EV_NONE);
      if (ev != EV_NONE) chk("exc_pc", exc_pc, (ev == EV_ERET) ? m_epc : 32'h0);
      chk($sformatf("rdata@%h", cp0_addr), cp0_rdata, m_read(cp0_addr));
    end
  endtask

  task automatic tick();
    int ev;
    logic [31:0] n_count;
    logic n_ti;
    @(posedge clk);
    if (!resetn) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_tog = 0; m_ti = 0;
      m_exl = 0; m_ie = 0; m_im = 0; m_sw = 0; m_hwq = 0; m_code = 0; m_live = 1;
    end else if (m_live) begin
      ev      = m_event();
      n_count = m_count + (m_tog ? 1 : 0);
      n_ti    = m_ti || (m_count == m_compare);
      if (ev != EV_NONE && ev != EV_ERET) begin
        m_code = 5'(ev);
        if (!m_exl) m_epc = wb_pc;
        m_exl = 1;
        if (ev == 4 || ev == 5) m_badv = bad_addr;
      end else if (ev == EV_ERET) begin
        m_exl = 0;
      end else if (wb_valid && mtc0) begin
        case (cp0_addr)
          A_COUNT:   n_count = cp0_wdata;
          A_COMPARE: begin m_compare = cp0_wdata; n_ti = 0; end
          A_STATUS:  begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
          A_CAUSE:   m_sw = cp0_wdata[9:8];
          A_EPC:     m_epc = cp0_wdata;
          default: ;
        endcase
      end
      m_count = n_count; m_ti = n_ti; m_tog = ~m_tog; m_hwq = hw_int;
    end
    #1;
  endtask

  task automatic step(); sample(); tick(); endtask

  task automatic clear_in();
    wb_valid = 0; {syscall, brk, ov, adel, ades, ri, eret, mtc0} = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wb_valid = 1; mtc0 = 1; cp0_addr = a; cp0_wdata = d;
    step();
    clear_in();
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] mask,
                    input logic [31:0] exp);
    cp0_addr = a;
    sample();
    chk(tag, cp0_rdata & mask, exp);
    tick();
  endtask

  logic [7:0] addrs[8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h61};

  initial begin
    // reset
    clear_in(); resetn = 0;
    step(); step();
    resetn = 1;
    cp0_addr = A_STATUS;
    sample();
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_cancel", cancel, 0);
    chk("rst_status", cp0_rdata, 0);
    tick();
    for (int i = 0; i < 8; i++) begin cp0_addr = addrs[i]; step(); end

    // timer interrupt
    wr(A_COMPARE, 32'd10);
    wr(A_STATUS, 32'h0000_8001);
    cp0_addr = A_CAUSE;
    for (int i = 0; i < 60 && !m_ti; i++) step();
    rd("ti_set", A_CAUSE, 32'h4000_0000, 32'h4000_0000);
    wb_valid = 1; wb_pc = 32'h100;
    sample();
    chk("int_valid", exc_valid, 1);
    chk("int_pc", exc_pc, 32'h0);
    tick(); clear_in();
    rd("int_code", A_CAUSE, 32'h7C, 32'h0);
    rd("int_epc", A_EPC, 32'hFFFF_FFFF, 32'h100);
    rd("int_exl", A_STATUS, 32'h2, 32'h2);

    // syscall then eret
    wr(A_STATUS, 32'h0);
    wb_valid = 1; syscall = 1; wb_pc = 32'h40;
    sample(); chk("sys_pc", exc_pc, 32'h0); tick(); clear_in();
    rd("sys_epc", A_EPC, 32'hFFFF_FFFF, 32'h40);
    rd("sys_code", A_CAUSE, 32'h7C, 32'd8 << 2);
    wb_valid = 1; eret = 1;
    sample(); chk("eret_valid", exc_valid, 1); chk("eret_pc", exc_pc, 32'h40); tick(); clear_in();
    rd("eret_exl", A_STATUS, 32'h2, 32'h0);

    // adel beats ov; ov alone leaves BadVAddr
    wb_valid = 1; adel = 1; ov = 1; bad_addr = 32'h1003; wb_pc = 32'h60;
    step(); clear_in();
    rd("adel_code", A_CAUSE, 32'h7C, 32'd4 << 2);
    rd("adel_badv", A_BADV, 32'hFFFF_FFFF, 32'h1003);
    wb_valid = 1; ov = 1; bad_addr = 32'h2222;
    step(); clear_in();
    rd("ov_badv", A_BADV, 32'hFFFF_FFFF, 32'h1003);
    rd("ov_code", A_CAUSE, 32'h7C, 32'd12 << 2);

    // nested syscall keeps EPC
    wb_valid = 1; eret = 1; step(); clear_in();
    wb_valid = 1; syscall = 1; wb_pc = 32'h40; step();
    wb_pc = 32'h80; step(); clear_in();
    rd("nest_epc", A_EPC, 32'hFFFF_FFFF, 32'h40);
    rd("nest_code", A_CAUSE, 32'h7C, 32'd8 << 2);
    wb_valid = 1; eret = 1; step(); clear_in();

    // Compare write racing a match, then Count wrap
    wr(A_COMPARE, m_count);
    rd("cmp_race_ti", A_CAUSE, 32'h4000_0000, 32'h0);
    wr(A_COUNT, 32'hFFFF_FFFF);
    cp0_addr = A_COUNT; step();
    rd("count_wrap", A_COUNT, 32'hFFFF_FFFF, 32'h0);

    // hardware interrupt with a suppressed same-cycle mtc0
    hw_int = 2'b10;
    wr(A_STATUS, 32'h0000_0801);
    wb_valid = 1; mtc0 = 1; cp0_addr = A_STATUS; cp0_wdata = 32'h0;
    sample(); chk("hw_int_valid", exc_valid, 1); chk("hw_int_cancel", cancel, 1); tick(); clear_in();
    rd("mtc0_suppressed", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0803);
    rd("hw_ip", A_CAUSE, 32'h0000_0C7C, 32'h0000_0800);

    // reset wins over an exception in the same cycle
    hw_int = '0;
    wb_valid = 1; syscall = 1; wb_pc = 32'h44; resetn = 0;
    step(); resetn = 1; clear_in();
    rd("rst_exc_epc", A_EPC, 32'hFFFF_FFFF, 32'h0);
    rd("rst_exc_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      resetn    = ($urandom_range(0, 199) != 0);
      wb_valid  = 1'($urandom_range(0, 1));
      syscall   = ($urandom_range(0, 9) == 0);
      brk       = ($urandom_range(0, 9) == 0);
      ov        = ($urandom_range(0, 9) == 0);
      adel      = ($urandom_range(0, 9) == 0);
      ades      = ($urandom_range(0, 9) == 0);
      ri        = ($urandom_range(0, 9) == 0);
      eret      = ($urandom_range(0, 7) == 0);
      mtc0      = ($urandom_range(0, 2) == 0);
      cp0_addr  = addrs[$urandom_range(0, 7)];
      cp0_wdata = $urandom;
      wb_pc     = $urandom;
      bad_addr  = $urandom;
      if ($urandom_range(0, 15) == 0) hw_int = NHW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
